mux4_serializer: RTL and testbench
==================================

MUX4_SERIALIZER -- requirements
Module: mux4_serializer

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 0, meaning 0 = emit a[0] first, 1 = emit a[3] first.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_data  input  4  parallel word to serialize.
REQ-005 SHALL have port in_valid  input  1  in_data valid.
REQ-006 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL have port out_bit  output  1  current serial bit, from the internal 4:1 mux.
REQ-008 SHALL have port out_valid  output  1  out_bit valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts out_bit this cycle.
REQ-010 SHALL have port out_last  output  1  out_bit is the 4th bit of the word.
REQ-011 SHALL have port sel  output  2  current mux select, for debug and coverage.

Function
REQ-012 SHALL implement a 2-state FSM: IDLE and SHIFT.
REQ-013 Input transfer SHALL occur on a rising edge when in_valid && in_ready; output transfer SHALL occur on a rising edge when out_valid && out_ready.
REQ-014 In IDLE: in_ready=1, out_valid=0; on an input transfer, capture in_data into data_q, load cnt=0, and go to SHIFT.
REQ-015 In SHIFT: out_valid=1; out_bit = data_q[sel]; sel = cnt when MSB_FIRST=0, else 3-cnt.
REQ-016 out_last SHALL be 1 exactly when state=SHIFT and cnt=3.
REQ-017 On an output transfer with cnt<3: cnt increments by 1 and state stays SHIFT.
REQ-018 On an output transfer with cnt=3: go to IDLE. If in_valid is also 1 in that cycle, capture in_data, load cnt=0, and stay in SHIFT (back-to-back).
REQ-019 in_ready SHALL equal (state=IDLE) || (state=SHIFT && cnt=3 && out_ready); this is the only combinational path from input to output.
REQ-020 While out_valid=1 and out_ready=0, out_bit, out_last, sel and data_q SHALL hold stable.
REQ-021 data_q SHALL NOT change in SHIFT except via the back-to-back capture in REQ-018; in_data changes mid-word SHALL have no effect.
REQ-022 Sustained throughput SHALL be 4 bits per 4 cycles with out_ready=1; first out_bit valid 1 cycle after the input transfer.
REQ-023 cnt SHALL be 2 bits and SHALL wrap 3->0 only through the reload in REQ-018.

Reset
REQ-024 While rst_n=0: state=IDLE, cnt=0, data_q=0; out_valid=0, out_last=0, out_bit=0, sel=0 (MSB_FIRST=0) or 3 (MSB_FIRST=1), in_ready=1 once rst_n deasserts.
REQ-025 Reset asserted mid-word SHALL discard the word immediately (asynchronously); no partial bits SHALL be emitted after release.

Structure
REQ-026 State encoding (IDLE/SHIFT) and the word width constant (4) SHALL be defined in shared package mux_pkg.
REQ-027 out_bit SHALL be produced by instantiating the existing combinational mux sub-module mux4_1 (a=data_q, sel=sel, y=out_bit); no duplicate mux logic.
REQ-028 State, cnt and data_q SHALL be the only registers; the outputs SHALL be decoded from them.

Verification
REQ-029 Scenario: MSB_FIRST=0, in_data=4'b1011, out_ready=1 -> out_bit 1,1,0,1 on consecutive cycles, out_last high on the 4th, then out_valid=0.
REQ-030 Scenario: MSB_FIRST=1, in_data=4'b1011 -> out_bit 1,0,1,1, sel 3,2,1,0.
REQ-031 Scenario: words 4'hA then 4'h5 with in_valid held and out_ready=1 -> 8 contiguous valid bits 0,1,0,1,1,0,1,0 with no bubble, and in_ready pulsing high on each out_last cycle.
REQ-032 Scenario: out_ready=0 for 3 cycles at cnt=1 -> out_bit and sel frozen; the sequence resumes unchanged and no bits are lost or duplicated.
REQ-033 Scenario: in_data toggles during SHIFT -> emitted bits match the captured word only.
REQ-034 Scenario: rst_n low at cnt=2 -> out_valid drops without waiting for clk; after release, in_ready=1 and the next word serializes from bit 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the 4-bit serializer: word width and FSM state encoding.
package mux_pkg;

  localparam int unsigned WORD_W = 4;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/mux4_1.sv
// Combinational 4:1 bit multiplexer.
module mux4_1
  import mux_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [CNT_W-1:0]  sel,
  output logic              y
);

  assign y = a[sel];

endmodule

// File: rtl/mux4_serializer.sv
// Serializes a 4-bit word onto a valid/ready bit stream via a 4:1 mux,
// with back-to-back word acceptance on the last bit.
module mux4_serializer
  import mux_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [CNT_W-1:0]  sel
);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_data_q;

  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [WORD_W-1:0] w_data_nxt;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_cnt_max;

  assign w_cnt_max  = (r_cnt == 2'd3);
  assign in_ready   = (r_state == IDLE) || ((r_state == SHIFT) && w_cnt_max && out_ready);
  assign out_valid  = (r_state == SHIFT);
  assign out_last   = (r_state == SHIFT) && w_cnt_max;
  assign sel        = MSB_FIRST ? (2'd3 - r_cnt) : r_cnt;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data_q;
    case (r_state)
      IDLE: begin
        if (w_in_xfer) begin
          w_data_nxt  = in_data;
          w_cnt_nxt   = '0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_out_xfer) begin
          if (!w_cnt_max) begin
            w_cnt_nxt = r_cnt + 2'd1;
          end else if (w_in_xfer) begin
            // last bit leaves while the next word arrives: reload without a bubble
            w_data_nxt = in_data;
            w_cnt_nxt  = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_data_q <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_data_q <= w_data_nxt;
    end
  end

  mux4_1 u_mux (
    .a   (r_data_q),
    .sel (sel),
    .y   (out_bit)
  );

endmodule

// File: tb/tb_mux4_serializer.sv
// Directed bench for mux4_serializer: LSB-first and MSB-first instances share stimulus.
module tb_mux4_serializer;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_data;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready0, out_bit0, out_valid0, out_last0;
  logic [1:0] sel0;
  logic       in_ready1, out_bit1, out_valid1, out_last1;
  logic [1:0] sel1;

  int checks;
  int failures;

  mux4_serializer #(.MSB_FIRST(1'b0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .out_bit   (out_bit0),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .out_last  (out_last0),
    .sel       (sel0)
  );

  mux4_serializer #(.MSB_FIRST(1'b1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .out_bit   (out_bit1),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_last  (out_last1),
    .sel       (sel1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 4'h0;
    #12;
    checks++;
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got %b/%b want 0/0", out_valid0, out_valid1);
    end
    checks++;
    if (out_last0 !== 1'b0 || out_last1 !== 1'b0 || out_bit0 !== 1'b0 || out_bit1 !== 1'b0) begin
      failures++; $display("FAIL reset_last_bit got last %b/%b bit %b/%b want 0", out_last0, out_last1, out_bit0, out_bit1);
    end
    checks++;
    if (sel0 !== 2'd0 || sel1 !== 2'd3) begin
      failures++; $display("FAIL reset_sel got %0d/%0d want 0/3", sel0, sel1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got %b/%b want 1/1", in_ready0, in_ready1);
    end
  endtask

  task automatic test_single_word();
    logic [3:0] w;
    w = 4'b1011;
    cyc();
    in_data = w; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
      failures++; $display("FAIL single_idle got in_ready %b out_valid %b want 1 0", in_ready0, out_valid0);
    end
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (out_valid0 !== 1'b1 || out_bit0 !== w[i] || sel0 !== 2'(i) || out_last0 !== (i == 3)) begin
        failures++; $display("FAIL lsb_bit%0d got v%b b%b s%0d l%b want v1 b%b s%0d l%b",
                             i, out_valid0, out_bit0, sel0, out_last0, w[i], i, (i == 3));
      end
      checks++;
      if (out_valid1 !== 1'b1 || out_bit1 !== w[3-i] || sel1 !== 2'(3-i) || out_last1 !== (i == 3)) begin
        failures++; $display("FAIL msb_bit%0d got v%b b%b s%0d l%b want v1 b%b s%0d l%b",
                             i, out_valid1, out_bit1, sel1, out_last1, w[3-i], 3-i, (i == 3));
      end
      checks++;
      if (in_ready0 !== (i == 3)) begin
        failures++; $display("FAIL single_in_ready%0d got %b want %b", i, in_ready0, (i == 3));
      end
      cyc();
    end
    #1;
    checks++;
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
      failures++; $display("FAIL single_done got %b/%b want 0/0", out_valid0, out_valid1);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] w;
    logic [7:0] exp0;
    logic [7:0] exp1;
    exp0 = 8'b01011010;  // bit k = k-th emitted bit, LSB-first: 0,1,0,1,1,0,1,0
    exp1 = 8'b10100101;  // MSB-first: 1,0,1,0,0,1,0,1
    cyc();
    in_data = 4'hA; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    in_data = 4'h5;
    for (int k = 0; k < 8; k++) begin
      #1;
      w = (k < 4) ? 4'hA : 4'h5;
      checks++;
      if (out_valid0 !== 1'b1 || out_bit0 !== exp0[k] || out_bit1 !== exp1[k]) begin
        failures++; $display("FAIL b2b_bit%0d got v%b b%b/%b want v1 b%b/%b word %h",
                             k, out_valid0, out_bit0, out_bit1, exp0[k], exp1[k], w);
      end
      checks++;
      if (in_ready0 !== ((k % 4) == 3) || out_last0 !== ((k % 4) == 3)) begin
        failures++; $display("FAIL b2b_ready%0d got rdy %b last %b want %b", k, in_ready0, out_last0, ((k % 4) == 3));
      end
      cyc();
      if (k == 3) in_valid = 1'b0;
    end
    #1;
    checks++;
    if (out_valid0 !== 1'b0) begin
      failures++; $display("FAIL b2b_done got %b want 0", out_valid0);
    end
  endtask

  task automatic test_stall();
    logic [3:0] w;
    w = 4'b0011;
    cyc();
    in_data = w; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      checks++;
      if (out_valid0 !== 1'b1 || out_bit0 !== w[1] || sel0 !== 2'd1 || in_ready0 !== 1'b0 ||
          out_bit1 !== w[2] || sel1 !== 2'd2) begin
        failures++; $display("FAIL stall%0d got v%b b%b/%b s%0d/%0d rdy%b want v1 b%b/%b s1/2 rdy0",
                             s, out_valid0, out_bit0, out_bit1, sel0, sel1, in_ready0, w[1], w[2]);
      end
      cyc();
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      #1;
      checks++;
      if (out_valid0 !== 1'b1 || out_bit0 !== w[i] || sel0 !== 2'(i) || out_bit1 !== w[3-i]) begin
        failures++; $display("FAIL resume_bit%0d got v%b b%b/%b s%0d want v1 b%b/%b s%0d",
                             i, out_valid0, out_bit0, out_bit1, sel0, w[i], w[3-i], i);
      end
      cyc();
    end
    #1;
    checks++;
    if (out_valid0 !== 1'b0) begin
      failures++; $display("FAIL stall_done got %b want 0", out_valid0);
    end
  endtask

  task automatic test_in_data_toggle();
    logic [3:0] w;
    logic [3:0] noise [4];
    w = 4'b1001;
    noise = '{4'h6, 4'hF, 4'h0, 4'h7};
    cyc();
    in_data = w; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      in_data = noise[i];
      if (i == 3) in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid0 !== 1'b1 || out_bit0 !== w[i] || out_bit1 !== w[3-i]) begin
        failures++; $display("FAIL toggle_bit%0d got v%b b%b/%b want v1 b%b/%b",
                             i, out_valid0, out_bit0, out_bit1, w[i], w[3-i]);
      end
      cyc();
    end
    #1;
    checks++;
    if (out_valid0 !== 1'b0) begin
      failures++; $display("FAIL toggle_done got %b want 0", out_valid0);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [3:0] w;
    cyc();
    in_data = 4'b1011; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    #1;
    checks++;
    if (out_valid0 !== 1'b1 || sel0 !== 2'd2) begin
      failures++; $display("FAIL pre_reset got v%b s%0d want v1 s2", out_valid0, sel0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || out_last0 !== 1'b0 || out_bit0 !== 1'b0) begin
      failures++; $display("FAIL async_reset got v%b/%b l%b b%b want 0", out_valid0, out_valid1, out_last0, out_bit0);
    end
    checks++;
    if (sel0 !== 2'd0 || sel1 !== 2'd3) begin
      failures++; $display("FAIL async_reset_sel got %0d/%0d want 0/3", sel0, sel1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    checks++;
    if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
      failures++; $display("FAIL post_reset got rdy %b v%b want 1 0", in_ready0, out_valid0);
    end
    w = 4'b1110;
    in_data = w; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (out_valid0 !== 1'b1 || out_bit0 !== w[i] || sel0 !== 2'(i)) begin
        failures++; $display("FAIL post_reset_bit%0d got v%b b%b s%0d want v1 b%b s%0d",
                             i, out_valid0, out_bit0, sel0, w[i], i);
      end
      cyc();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_in_data_toggle();
    test_reset_mid_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
